// File: rtl/zero_runner_pkg.sv
// Shared definitions for zero_runner: opcodes, sequencer states and helpers
// that pull fields out of an instruction word {op, a, imm, tgt}.
package zero_runner_pkg;

   localparam logic [2:0] OP_LABEL = 3'd0;
   localparam logic [2:0] OP_JMP   = 3'd1;
   localparam logic [2:0] OP_JEQ   = 3'd2;
   localparam logic [2:0] OP_JNE   = 3'd3;
   localparam logic [2:0] OP_JLT   = 3'd4;
   localparam logic [2:0] OP_MOV   = 3'd5;
   localparam logic [2:0] OP_ADD   = 3'd6;
   localparam logic [2:0] OP_OUT   = 3'd7;

   localparam int INSTR_MAX_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_STALL,
      ST_DONE
   } state_t;

   typedef logic [INSTR_MAX_W-1:0] instr_word_t;

   // Instruction words are zero-extended into instr_word_t so one set of
   // helpers serves every parameterisation; callers size-cast the result.
   function automatic instr_word_t instr_field(input instr_word_t w, input int lsb,
                                               input int width);
      return (w >> lsb) & ((instr_word_t'(1) << width) - instr_word_t'(1));
   endfunction

   function automatic logic [2:0] instr_op(input instr_word_t w, input int iw);
      return 3'(w >> (iw - 3));
   endfunction

   function automatic instr_word_t instr_a(input instr_word_t w, input int la,
                                           input int dw, input int ta);
      return instr_field(w, dw + ta, la);
   endfunction

   function automatic instr_word_t instr_imm(input instr_word_t w, input int dw,
                                             input int ta);
      return instr_field(w, ta, dw);
   endfunction

   function automatic instr_word_t instr_tgt(input instr_word_t w, input int ta);
      return instr_field(w, 0, ta);
   endfunction

endpackage

// File: rtl/zero_runner_if.sv
// Control, program-load and result-stream signals of zero_runner.
// outValid/outReady: a word moves on every rising edge where both are high;
// outData stays stable while outValid is high and outReady is low.
interface zero_runner_if #(
   parameter int W      = 12,
   parameter int NInstr = 16,
   parameter int NLocal = 8
);
   localparam int LA  = $clog2(NLocal);
   localparam int IAW = $clog2(NInstr);
   localparam int TA  = IAW + 1;
   localparam int IW  = 3 + LA + W + TA;

   logic           run;
   logic           loadValid;
   logic [IAW-1:0] loadAddr;
   logic [IW-1:0]  loadData;
   logic           outValid;
   logic           outReady;
   logic [W-1:0]   outData;
   logic           finished;
   logic           success;
   logic           timeout;
   logic [31:0]    stepCount;

   modport master (
      output run, loadValid, loadAddr, loadData, outReady,
      input  outValid, outData, finished, success, timeout, stepCount
   );

   modport slave (
      input  run, loadValid, loadAddr, loadData, outReady,
      output outValid, outData, finished, success, timeout, stepCount
   );

endinterface

// File: rtl/zero_runner_fifo.sv
// Synchronous result FIFO with occupancy count and flush; a push is dropped
// when full and a pop when empty.
module zero_runner_fifo #(
   parameter int W    = 12,
   parameter int NOut = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [W-1:0]               i_data,
   input  logic                       i_pop,
   output logic [W-1:0]               o_data,
   output logic                       o_valid,
   output logic [$clog2(NOut+1)-1:0]  o_count
);

   localparam int PW = (NOut > 1) ? $clog2(NOut) : 1;
   localparam int CW = $clog2(NOut + 1);
   localparam logic [CW-1:0] FULL = CW'(NOut);

   logic [W-1:0]  r_mem [NOut];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   // Pointers wrap explicitly so depths that are not a power of two work.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(NOut - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_push  = i_push && (r_count != FULL);
   assign w_pop   = i_pop && (r_count != '0);
   assign o_valid = (r_count != '0);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/zero_runner.sv
// Program-image instruction sequencer: one instruction per RUN cycle, results
// streamed through a small FIFO, with finished/success/timeout reporting.
module zero_runner
   import zero_runner_pkg::*;
#(
   parameter int W        = 12,
   parameter int NInstr   = 16,
   parameter int NLocal   = 8,
   parameter int NOut     = 4,
   parameter int MaxSteps = 1000
) (
   input  logic         clock,
   input  logic         reset,
   zero_runner_if.slave bus,
   output state_t       o_dbg_state
);

   localparam int LA  = $clog2(NLocal);
   localparam int IAW = $clog2(NInstr);
   localparam int TA  = IAW + 1;
   localparam int IW  = 3 + LA + W + TA;
   localparam int CW  = $clog2(NOut + 1);
   localparam logic [TA-1:0] END_IP    = TA'(NInstr);
   localparam logic [31:0]   MAX_STEPS = 32'(MaxSteps);

   // Program memory has no reset so a loaded image survives reset; it relies
   // on the device powering up with zeroed storage (all-zero word = nop).
   logic [IW-1:0] r_imem [NInstr];
   logic [W-1:0]  r_local [NLocal];

   state_t        r_state, w_state_nxt;
   logic [TA-1:0] r_ip, w_ip_nxt;
   logic [31:0]   r_steps, w_steps_nxt;
   logic          r_finished, w_fin_nxt;
   logic          r_success, w_succ_nxt;
   logic          r_timeout, w_to_nxt;

   logic          w_start;
   logic          w_push;
   logic          w_local_we;
   logic [W-1:0]  w_local_wdata;
   logic          w_load_ok;

   logic          w_end;
   logic [IW-1:0] w_instr;
   instr_word_t   w_word;
   logic [2:0]    w_op;
   logic [LA-1:0] w_a;
   logic [W-1:0]  w_imm;
   logic [TA-1:0] w_tgt;
   logic [W-1:0]  w_la_val;
   logic [TA-1:0] w_ip_inc;

   logic [CW-1:0] w_fifo_count;
   logic          w_fifo_full;

   assign w_end    = (r_ip >= END_IP);
   assign w_instr  = r_imem[r_ip[IAW-1:0]];
   assign w_word   = instr_word_t'(w_instr);
   assign w_op     = instr_op(w_word, IW);
   assign w_a      = LA'(instr_a(w_word, LA, W, TA));
   assign w_imm    = W'(instr_imm(w_word, W, TA));
   assign w_tgt    = TA'(instr_tgt(w_word, TA));
   assign w_la_val = r_local[w_a];
   assign w_ip_inc = r_ip + TA'(1);

   assign w_fifo_full = (w_fifo_count == CW'(NOut));
   assign w_load_ok   = bus.loadValid && (r_state == ST_IDLE || r_state == ST_DONE);

   always_comb begin
      w_state_nxt   = r_state;
      w_ip_nxt      = r_ip;
      w_steps_nxt   = r_steps;
      w_fin_nxt     = r_finished;
      w_succ_nxt    = r_success;
      w_to_nxt      = r_timeout;
      w_start       = 1'b0;
      w_push        = 1'b0;
      w_local_we    = 1'b0;
      w_local_wdata = w_la_val;

      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.run) begin
               w_start     = 1'b1;
               w_state_nxt = ST_RUN;
               w_ip_nxt    = '0;
               w_steps_nxt = '0;
               w_fin_nxt   = 1'b0;
               w_succ_nxt  = 1'b0;
               w_to_nxt    = 1'b0;
            end
         end
         ST_RUN: begin
            if (w_end) begin
               w_state_nxt = ST_DONE;
               w_fin_nxt   = 1'b1;
               w_succ_nxt  = 1'b1;
            end else if (r_steps == MAX_STEPS) begin
               w_state_nxt = ST_DONE;
               w_fin_nxt   = 1'b1;
               w_to_nxt    = 1'b1;
               w_succ_nxt  = 1'b0;
            end else if (w_op == OP_OUT && w_fifo_full) begin
               // Full means full this cycle, even if the head is being popped.
               w_state_nxt = ST_STALL;
            end else begin
               w_steps_nxt = r_steps + 32'd1;
               w_ip_nxt    = w_ip_inc;
               case (w_op)
                  OP_JMP: w_ip_nxt = w_tgt;
                  OP_JEQ: if (w_la_val == w_imm) w_ip_nxt = w_tgt;
                  OP_JNE: if (w_la_val != w_imm) w_ip_nxt = w_tgt;
                  OP_JLT: if (w_la_val < w_imm) w_ip_nxt = w_tgt;
                  OP_MOV: begin
                     w_local_we    = 1'b1;
                     w_local_wdata = w_imm;
                  end
                  OP_ADD: begin
                     w_local_we    = 1'b1;
                     w_local_wdata = w_la_val + w_imm;
                  end
                  OP_OUT:  w_push = 1'b1;
                  default: ;
               endcase
            end
         end
         ST_STALL: begin
            if (!w_fifo_full) w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_ip       <= '0;
         r_steps    <= '0;
         r_finished <= 1'b0;
         r_success  <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ip       <= w_ip_nxt;
         r_steps    <= w_steps_nxt;
         r_finished <= w_fin_nxt;
         r_success  <= w_succ_nxt;
         r_timeout  <= w_to_nxt;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NLocal; i++) r_local[i] <= '0;
      end else if (w_start) begin
         for (int i = 0; i < NLocal; i++) r_local[i] <= '0;
      end else if (w_local_we) begin
         r_local[w_a] <= w_local_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (w_load_ok) r_imem[bus.loadAddr] <= bus.loadData;
   end

   zero_runner_fifo #(
      .W    (W),
      .NOut (NOut)
   ) u_fifo (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_flush (w_start),
      .i_push  (w_push),
      .i_data  (w_la_val),
      .i_pop   (bus.outReady),
      .o_data  (bus.outData),
      .o_valid (bus.outValid),
      .o_count (w_fifo_count)
   );

   assign bus.finished  = r_finished;
   assign bus.success   = r_success;
   assign bus.timeout   = r_timeout;
   assign bus.stepCount = r_steps;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_zero_runner.sv
// Self-checking bench for zero_runner: small programs loaded as images,
// outputs checked in order against an expected queue.
module tb_zero_runner;
   import zero_runner_pkg::*;

   localparam int W  = 12;
   localparam int NI = 8;
   localparam int NL = 8;
   localparam int NO = 4;
   localparam int MS = 1000;
   localparam int IW = 3 + 3 + W + 4;

   logic   clock = 1'b0;
   logic   reset;
   state_t dbg_state;

   always #5 clock = ~clock;

   zero_runner_if #(.W(W), .NInstr(NI), .NLocal(NL)) bus ();

   zero_runner #(
      .W(W), .NInstr(NI), .NLocal(NL), .NOut(NO), .MaxSteps(MS)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  mon_exp;
   logic [IW-1:0] prog [NI];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [IW-1:0] enc(input logic [2:0] op, input logic [2:0] a,
                                         input logic [11:0] imm, input logic [3:0] tgt);
      return {op, a, imm, tgt};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < NI; i++) prog[i] = '0;
   endtask

   task automatic load_prog();
      for (int i = 0; i < NI; i++) begin
         tick();
         bus.loadValid = 1'b1;
         bus.loadAddr  = 3'(i);
         bus.loadData  = prog[i];
      end
      tick();
      bus.loadValid = 1'b0;
   endtask

   task automatic start_run();
      tick();
      bus.run = 1'b1;
      tick();
      bus.run = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (!bus.finished && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(bus.finished), 32'd1);
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_end(input string tag, input logic succ, input logic to,
                            input int steps);
      check({tag, "_success"}, 32'(bus.success), 32'(succ));
      check({tag, "_timeout"}, 32'(bus.timeout), 32'(to));
      check({tag, "_steps"}, bus.stepCount, 32'(steps));
      check({tag, "_state"}, 32'(dbg_state), 32'(ST_DONE));
   endtask

   always @(negedge clock) begin
      if (!reset && bus.outValid && bus.outReady) begin
         if (exp_q.size() == 0) begin
            check("out_unexpected", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_exp = exp_q.pop_front();
            check("out_data", 32'(bus.outData), 32'(mon_exp));
         end
      end
   end

   initial begin
      bus.run       = 1'b0;
      bus.loadValid = 1'b0;
      bus.loadAddr  = '0;
      bus.loadData  = '0;
      bus.outReady  = 1'b0;
      reset         = 1'b1;
      repeat (3) tick();
      check("rst_valid", 32'(bus.outValid), 32'd0);
      check("rst_finished", 32'(bus.finished), 32'd0);
      check("rst_success", 32'(bus.success), 32'd0);
      check("rst_timeout", 32'(bus.timeout), 32'd0);
      check("rst_steps", bus.stepCount, 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      reset = 1'b0;
      tick();

      // Jump-over
      clear_prog();
      prog[0] = enc(OP_JMP, 3'd0, 12'd0, 4'd3);
      prog[1] = enc(OP_OUT, 3'd0, 12'd0, 4'd0);
      prog[2] = enc(OP_JMP, 3'd0, 12'd0, 4'd6);
      prog[3] = enc(OP_LABEL, 3'd0, 12'd0, 4'd0);
      prog[4] = enc(OP_MOV, 3'd0, 12'd2, 4'd0);
      prog[5] = enc(OP_OUT, 3'd0, 12'd0, 4'd0);
      load_prog();
      bus.outReady = 1'b1;
      exp_q.push_back(12'd2);
      start_run();
      wait_done("jo_done", 200);
      check_end("jo", 1'b1, 1'b0, 6);
      wait_drain("jo_drain");

      // Counted loop
      clear_prog();
      prog[0] = enc(OP_MOV, 3'd0, 12'd0, 4'd0);
      prog[1] = enc(OP_ADD, 3'd0, 12'd1, 4'd0);
      prog[2] = enc(OP_OUT, 3'd0, 12'd0, 4'd0);
      prog[3] = enc(OP_JLT, 3'd0, 12'd3, 4'd1);
      load_prog();
      for (int v = 1; v <= 3; v++) exp_q.push_back(W'(v));
      start_run();
      wait_done("loop_done", 200);
      check_end("loop", 1'b1, 1'b0, 14);
      wait_drain("loop_drain");

      // Backpressure: 5 outs (10..14) into a 4-deep FIFO with ready low
      clear_prog();
      prog[0] = enc(OP_MOV, 3'd0, 12'd10, 4'd0);
      prog[1] = enc(OP_OUT, 3'd0, 12'd0, 4'd0);
      prog[2] = enc(OP_ADD, 3'd0, 12'd1, 4'd0);
      prog[3] = enc(OP_JLT, 3'd0, 12'd15, 4'd1);
      load_prog();
      bus.outReady = 1'b0;
      for (int v = 10; v <= 14; v++) exp_q.push_back(W'(v));
      start_run();
      repeat (20) tick();
      check("bp_state", 32'(dbg_state), 32'(ST_STALL));
      check("bp_steps", bus.stepCount, 32'd13);
      check("bp_valid", 32'(bus.outValid), 32'd1);
      check("bp_finished", 32'(bus.finished), 32'd0);
      repeat (5) tick();
      check("bp_steps_frozen", bus.stepCount, 32'd13);
      bus.outReady = 1'b1;
      wait_done("bp_done", 200);
      check_end("bp", 1'b1, 1'b0, 20);
      wait_drain("bp_drain");

      // Wrap of W-bit add
      clear_prog();
      prog[0] = enc(OP_MOV, 3'd1, 12'd4095, 4'd0);
      prog[1] = enc(OP_ADD, 3'd1, 12'd1, 4'd0);
      prog[2] = enc(OP_OUT, 3'd1, 12'd0, 4'd0);
      load_prog();
      exp_q.push_back(12'd0);
      start_run();
      wait_done("wrap_done", 200);
      check_end("wrap", 1'b1, 1'b0, 8);
      wait_drain("wrap_drain");

      // Timeout
      clear_prog();
      prog[0] = enc(OP_JMP, 3'd0, 12'd0, 4'd0);
      load_prog();
      start_run();
      wait_done("to_done", 1200);
      check_end("to", 1'b0, 1'b1, 1000);

      // Reset mid-run; loads during RUN must be ignored, image kept over reset
      start_run();
      repeat (100) tick();
      bus.loadValid = 1'b1;
      bus.loadAddr  = 3'd0;
      bus.loadData  = enc(OP_LABEL, 3'd0, 12'd0, 4'd0);
      repeat (3) tick();
      bus.loadValid = 1'b0;
      repeat (200) tick();
      reset = 1'b1;
      @(negedge clock);
      check("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("mrst_steps", bus.stepCount, 32'd0);
      check("mrst_finished", 32'(bus.finished), 32'd0);
      check("mrst_timeout", 32'(bus.timeout), 32'd0);
      check("mrst_valid", 32'(bus.outValid), 32'd0);
      tick();
      reset = 1'b0;
      start_run();
      wait_done("rerun_done", 1200);
      check_end("rerun", 1'b0, 1'b1, 1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/zero_runner.md
# zero_runner

Parametrised, clocked instruction sequencer for the Zero FPGA test flow. It executes a loaded program of jump, compare-and-branch, move, add and out instructions at one instruction per cycle. Results stream through a ready/valid output FIFO, and the block reports finished/success/timeout. It replaces the per-test unrolled case-statement harnesses with one reusable block: tests load a program image instead of regenerating RTL.

## Interface
Parameters:
- `W`, 12: data / memory element width
- `NInstr`, 16: instruction memory depth
- `NLocal`, 8: local memory words
- `NOut`, 4: output FIFO depth (≥1)
- `MaxSteps`, 1000: step limit before timeout

Derived widths:
- `LA` = clog2(NLocal)
- `TA` = clog2(NInstr)+1 (target `NInstr` means "end")
- `IW` = 3+LA+W+TA

Ports:
- `clock` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-high
- `run` in 1: start pulse, sampled in IDLE/DONE
- `loadValid` in 1: write `loadData` to instruction memory at `loadAddr` (IDLE/DONE only)
- `loadAddr` in clog2(NInstr): instruction address
- `loadData` in IW: instruction word {op[2:0], a[LA], imm[W], tgt[TA]}, op in MSBs
- `outValid` out 1: FIFO head valid
- `outReady` in 1: consumer accepts head
- `outData` out W: FIFO head
- `finished` out 1: program ended (normal or timeout)
- `success` out 1: ended by reaching ip ≥ NInstr
- `timeout` out 1: ended by step limit
- `stepCount` out 32: instructions executed this run

## Operation
Opcodes:
- 0 `label`: nop, ip+1
- 1 `jmp`: ip=tgt
- 2 `jEq`: ip = (L[a]==imm) ? tgt : ip+1
- 3 `jNe`
- 4 `jLt`: unsigned compare
- 5 `mov`: L[a]=imm
- 6 `add`: L[a]=(L[a]+imm) mod 2^W
- 7 `out`: push L[a] to FIFO

States:
- IDLE → RUN on `run`. On entry: ip=0, stepCount=0, locals=0, FIFO flushed, finished/success/timeout=0.
- RUN, in priority order:
  - ip ≥ NInstr → DONE, finished=1, success=1.
  - stepCount==MaxSteps → DONE, finished=1, timeout=1, success=0.
  - `out` with FIFO full (count==NOut, even if a pop occurs this cycle) → STALL, no step counted.
  - Otherwise execute and stepCount+1.
- STALL → RUN in the cycle after count<NOut; the `out` then re-executes.
- DONE holds all flags; `run` restarts as from IDLE. The FIFO keeps draining in every state except on restart.

Other rules:
- `loadValid` during RUN/STALL is ignored. Unloaded words read as 0 (nop) after power-up; program memory is not cleared by `reset`.
- `run` during RUN/STALL is ignored.
- Reset (any time, mid-run included): state IDLE, all outputs 0, FIFO empty, locals 0, ip 0.
- Jump target > NInstr is treated as end (success).

## Timing
- One executed instruction per RUN cycle; branch has no penalty.
- `run` high at edge k: first instruction executes at edge k+1.
- End detection costs one RUN cycle with no step counted; `finished` is high after that edge.
- FIFO: a push at edge k gives `outValid`=1 after k. Pop occurs on `outValid&&outReady`. Push and pop in the same cycle with count<NOut leave the count unchanged, in order.

## Structure
- Package `zero_runner_pkg`: opcode localparams, state enum {IDLE,RUN,STALL,DONE}, instruction field-extract functions.
- Sub-module `zero_runner_fifo` (param W, NOut): synchronous FIFO with count, push/pop, flush, async reset.

## Test plan
- **Jump-over** (NInstr=8): 0 jmp 3; 1 out L0; 2 jmp 6; 3 label; 4 mov L0=2; 5 out L0; `outReady`=1 → single output 2, stepCount=6, finished=1, success=1, timeout=0.
- **Counted loop**: mov L0=0; add L0+=1; out L0; jLt L0,3→1 → outputs 1,2,3, stepCount=14, success=1.
- **Backpressure** (NOut=4): five `out`s of L0 with values 10..14, `outReady`=0 → stall at 5th out, stepCount frozen. Raise ready → 10,11,12,13,14 in order, then success=1.
- **Timeout** (MaxSteps=1000): 0 jmp 0 → finished=1, timeout=1, success=0, stepCount=1000.
- **Wrap**: mov L1=4095; add L1+=1; out L1 (W=12) → output 0.
- **Reset mid-run**: reset during timeout loop → all outputs 0, state IDLE. Re-run without reload → identical timeout result (program memory retained).
